// File: rtl/video_bank_writer_if.sv
// Byte-write port from video_bank_writer into the two-bank frame memory.
// Address is {bank, byte_addr}; each write is a single-cycle strobe with no back-pressure.
interface video_bank_writer_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [7:0]        mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/video_bank_writer.sv
// Deserializes the qualified SPI MISO stream into bytes and ping-pongs them into two frame banks.
// Define VIDEO_DROP_CNT_EN to add drop_count, a saturating count of frames the display repeated.
module video_bank_writer #(
    parameter int unsigned FRAME_BYTES = 9600,
    parameter int unsigned ADDR_W      = 14
) (
    input  logic                CLK_40,
    input  logic                reset_n,
    input  logic                SPI_clk_en,
    input  logic                MISO,
    input  logic                write_video,
    input  logic                frame_done,
    video_bank_writer_if.master mem_bus,
    output logic                video_bank_full,
`ifdef VIDEO_DROP_CNT_EN
    output logic [7:0]          drop_count,
`endif
    output logic                disp_bank
);

    typedef enum logic {StFill, StFull} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_BYTES - 1);

    state_e            state_q, state_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] byte_addr_q, byte_addr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              disp_bank_q, disp_bank_d;
    logic              full_q, full_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              frame_done_q;

    logic qual_bit, byte_done, last_byte, fd_evt;

    assign qual_bit  = SPI_clk_en & write_video;
    assign byte_done = (state_q == StFill) & qual_bit & (bit_cnt_q == 3'd7);
    assign last_byte = byte_done & (byte_addr_q == LastAddr);
    // A held-high frame_done counts once: only its rising edge is an event.
    assign fd_evt    = frame_done & ~frame_done_q;

    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:  if (last_byte) state_d = StFull;
            StFull:  if (fd_evt)    state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        byte_addr_d = byte_addr_q;
        wr_bank_d   = wr_bank_q;
        disp_bank_d = disp_bank_q;
        full_d      = full_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            StFill: begin
                if (qual_bit) begin
                    shreg_d   = {shreg_q[6:0], MISO};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {shreg_q[6:0], MISO};
                        mem_addr_d  = {wr_bank_q, byte_addr_q};
                        if (last_byte) begin
                            byte_addr_d = '0;
                            full_d      = 1'b1;
                        end else begin
                            byte_addr_d = byte_addr_q + 1'b1;
                        end
                    end
                end else if (SPI_clk_en) begin
                    // Qualifier dropped mid-byte: restart the byte at the same address.
                    bit_cnt_d = 3'd0;
                end
            end
            StFull: begin
                shreg_d   = 8'h00;
                bit_cnt_d = 3'd0;
                if (fd_evt) begin
                    disp_bank_d = wr_bank_q;
                    wr_bank_d   = ~wr_bank_q;
                    full_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_addr_q  <= '0;
            wr_bank_q    <= 1'b0;
            disp_bank_q  <= 1'b1;
            full_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_addr_q  <= byte_addr_d;
            wr_bank_q    <= wr_bank_d;
            disp_bank_q  <= disp_bank_d;
            full_q       <= full_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            frame_done_q <= frame_done;
        end
    end

`ifdef VIDEO_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 8'h00;
        end else if ((state_q == StFill) && fd_evt && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'h01;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign mem_bus.mem_we    = mem_we_q;
    assign mem_bus.mem_addr  = mem_addr_q;
    assign mem_bus.mem_wdata = mem_wdata_q;
    assign video_bank_full   = full_q;
    assign disp_bank         = disp_bank_q;

endmodule

// File: tb/tb_video_bank_writer.sv
// Directed bench for video_bank_writer with a 16-byte frame and a 4-bit byte address.
module tb_video_bank_writer;

    localparam int unsigned FB = 16;
    localparam int unsigned AW = 4;

    logic CLK_40 = 1'b0;
    logic reset_n, SPI_clk_en, MISO, write_video, frame_done;
    logic video_bank_full, disp_bank;
`ifdef VIDEO_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    video_bank_writer_if #(.ADDR_W(AW)) mem_bus ();

    video_bank_writer #(.FRAME_BYTES(FB), .ADDR_W(AW)) dut (
        .CLK_40          (CLK_40),
        .reset_n         (reset_n),
        .SPI_clk_en      (SPI_clk_en),
        .MISO            (MISO),
        .write_video     (write_video),
        .frame_done      (frame_done),
        .mem_bus         (mem_bus),
        .video_bank_full (video_bank_full),
`ifdef VIDEO_DROP_CNT_EN
        .drop_count      (drop_count),
`endif
        .disp_bank       (disp_bank)
    );

    always #5 CLK_40 = ~CLK_40;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // Write log, sampled on the falling edge so each one-cycle strobe is seen once.
    int unsigned wr_cnt = 0;
    logic [31:0] last_addr = 0;
    logic [31:0] last_data = 0;

    always @(negedge CLK_40) begin
        if (mem_bus.mem_we === 1'b1) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= 32'(mem_bus.mem_addr);
            last_data <= 32'(mem_bus.mem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic wv, input logic fd);
        @(negedge CLK_40);
        SPI_clk_en  = 1'b1;
        MISO        = b;
        write_video = wv;
        frame_done  = fd;
        @(negedge CLK_40);
        SPI_clk_en  = 1'b0;
        frame_done  = 1'b0;
    endtask

    // Leaves the caller on the falling edge where the resulting write strobe is visible.
    task automatic send_byte(input logic [7:0] b, input logic fd_on_last);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b1, (i == 0) ? fd_on_last : 1'b0);
    endtask

    task automatic pulse_fd();
        @(negedge CLK_40);
        frame_done = 1'b1;
        @(negedge CLK_40);
        frame_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK_40);
    endtask

    task automatic do_reset();
        @(negedge CLK_40);
        reset_n = 1'b0;
        @(negedge CLK_40);
        reset_n = 1'b1;
    endtask

    int unsigned w0;
    logic [7:0] pat;

    initial begin
        reset_n = 1'b0; SPI_clk_en = 1'b0; MISO = 1'b0; write_video = 1'b0; frame_done = 1'b0;
        idle(3);
        reset_n = 1'b1;
        check_eq("rst_full", 32'(video_bank_full), 0);
        check_eq("rst_disp", 32'(disp_bank), 1);
        check_eq("rst_we", 32'(mem_bus.mem_we), 0);

        // Single byte, then a second at the next address
        w0 = wr_cnt;
        send_byte(8'hA5, 1'b0);
        idle(2);
        check_eq("a5_count", wr_cnt - w0, 1);
        check_eq("a5_data", last_data, 32'hA5);
        check_eq("a5_addr", last_addr, 32'h00);
        send_byte(8'h3C, 1'b0);
        idle(2);
        check_eq("3c_count", wr_cnt - w0, 2);
        check_eq("3c_data", last_data, 32'h3C);
        check_eq("3c_addr", last_addr, 32'h01);

        // Asynchronous reset asserted mid-cycle
        @(posedge CLK_40);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_wdata", 32'(mem_bus.mem_wdata), 0);
        check_eq("arst_addr", 32'(mem_bus.mem_addr), 0);
        check_eq("arst_we", 32'(mem_bus.mem_we), 0);
        check_eq("arst_full", 32'(video_bank_full), 0);
        check_eq("arst_disp", 32'(disp_bank), 1);
        @(negedge CLK_40);
        reset_n = 1'b1;

        // Partial byte dropped when the qualifier falls during a strobe
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        idle(2);
        check_eq("part_nowrite", wr_cnt - w0, 0);
        send_byte(8'hFF, 1'b0);
        idle(2);
        check_eq("part_count", wr_cnt - w0, 1);
        check_eq("part_data", last_data, 32'hFF);
        check_eq("part_addr", last_addr, 32'h00);

        // Early frame_done after 3 bytes: no swap, address continues
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i), 1'b0);
        pulse_fd();
        idle(2);
        check_eq("early_disp", 32'(disp_bank), 1);
        check_eq("early_full", 32'(video_bank_full), 0);
`ifdef VIDEO_DROP_CNT_EN
        check_eq("early_drop", 32'(drop_count), 1);
`endif
        send_byte(8'h44, 1'b0);
        idle(1);
        check_eq("early_b4_addr", last_addr, 32'h03);
        check_eq("early_b4_data", last_data, 32'h44);

        // Fill the rest of bank 0; full rises with the final write
        for (int i = 4; i < 16; i++) begin
            pat = 8'(8'h80 + i);
            send_byte(pat, 1'b0);
            if (i < 15) check_eq("fill_notfull", 32'(video_bank_full), 0);
        end
        check_eq("fill_last_we", 32'(mem_bus.mem_we), 1);
        check_eq("fill_full", 32'(video_bank_full), 1);
        idle(1);
        check_eq("fill_last_addr", last_addr, 32'h0F);
        check_eq("fill_last_data", last_data, 32'h8F);
        w0 = wr_cnt;
        send_byte(8'h5A, 1'b0);
        send_byte(8'hC3, 1'b0);
        idle(2);
        check_eq("full_nowrite", wr_cnt - w0, 0);
        check_eq("full_hold", 32'(video_bank_full), 1);
        pulse_fd();
        check_eq("swap_disp", 32'(disp_bank), 0);
        check_eq("swap_full", 32'(video_bank_full), 0);
        send_byte(8'h77, 1'b0);
        idle(1);
        check_eq("swap_addr", last_addr, 32'h10);
        check_eq("swap_data", last_data, 32'h77);

        // Collision: frame_done on the final bit of bank 1 is ignored
        for (int i = 1; i < 15; i++) send_byte(8'(i), 1'b0);
        send_byte(8'hE7, 1'b1);
        check_eq("coll_full", 32'(video_bank_full), 1);
        idle(3);
        check_eq("coll_addr", last_addr, 32'h1F);
        check_eq("coll_noswap_disp", 32'(disp_bank), 0);
        check_eq("coll_noswap_full", 32'(video_bank_full), 1);
        pulse_fd();
        check_eq("coll_swap_disp", 32'(disp_bank), 1);
        check_eq("coll_swap_full", 32'(video_bank_full), 0);
        send_byte(8'h99, 1'b0);
        idle(1);
        check_eq("coll_next_addr", last_addr, 32'h00);

        // Many early frame_done pulses in FILL: no swap, counter saturates
        for (int i = 0; i < 300; i++) begin
            pulse_fd();
            @(negedge CLK_40);
        end
        check_eq("sat_disp", 32'(disp_bank), 1);
`ifdef VIDEO_DROP_CNT_EN
        check_eq("sat_drop", 32'(drop_count), 255);
`endif
        send_byte(8'h12, 1'b0);
        idle(1);
        check_eq("sat_next_addr", last_addr, 32'h01);
        check_eq("sat_next_data", last_data, 32'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
